// File: rtl/psum_serializer.sv
// Partial-sum serializer: collects pr rows of col psums, then streams them
// column-major (pr beats per column) to the downstream norm array.
module psum_serializer #(
  parameter int pr      = 8,
  parameter int col     = 8,
  parameter int bw      = 4,
  parameter int psum_bw = 2*bw+4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [col*psum_bw-1:0]   in_data,
  input  logic                     out_stall,
  output logic                     out_wr,
  output logic [psum_bw-1:0]       out_data,
  output logic                     done
);

  localparam int rw = (pr  > 1) ? $clog2(pr)  : 1;
  localparam int cw = (col > 1) ? $clog2(col) : 1;
  localparam logic [rw-1:0] row_last = rw'(pr - 1);
  localparam logic [cw-1:0] col_last = cw'(col - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t             state;
  logic [rw-1:0]      row_cnt;
  logic [rw-1:0]      r_ptr;
  logic [cw-1:0]      c_ptr;
  logic [psum_bw-1:0] buffer [0:pr-1][0:col-1];

  logic capture;
  logic last_beat;

  // Decode handshake and end-of-tile conditions
  always_comb begin
    in_ready  = (state == FILL);
    capture   = (state == FILL) && in_valid && !flush;
    last_beat = (r_ptr == row_last) && (c_ptr == col_last);
  end

  // Tile storage; contents are never read outside DRAIN, so no reset needed
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int c = 0; c < col; c++) begin
        buffer[row_cnt][c] <= in_data[c*psum_bw +: psum_bw];
      end
    end
  end

  // Fill/drain control with registered beat outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FILL;
      row_cnt  <= {rw{1'b0}};
      r_ptr    <= {rw{1'b0}};
      c_ptr    <= {cw{1'b0}};
      out_wr   <= 1'b0;
      done     <= 1'b0;
      out_data <= {psum_bw{1'b0}};
    end else if (flush) begin
      state   <= FILL;
      row_cnt <= {rw{1'b0}};
      r_ptr   <= {rw{1'b0}};
      c_ptr   <= {cw{1'b0}};
      out_wr  <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          out_wr <= 1'b0;
          done   <= 1'b0;
          if (in_valid) begin
            if (row_cnt == row_last) begin
              row_cnt <= {rw{1'b0}};
              r_ptr   <= {rw{1'b0}};
              c_ptr   <= {cw{1'b0}};
              state   <= DRAIN;
            end else begin
              row_cnt <= row_cnt + rw'(1);
            end
          end else begin
            row_cnt <= row_cnt;
          end
        end
        DRAIN: begin
          if (!out_stall) begin
            out_wr   <= 1'b1;
            out_data <= buffer[r_ptr][c_ptr];
            done     <= last_beat;
            if (last_beat) begin
              r_ptr <= {rw{1'b0}};
              c_ptr <= {cw{1'b0}};
              state <= FILL;
            end else if (r_ptr == row_last) begin
              r_ptr <= {rw{1'b0}};
              c_ptr <= c_ptr + cw'(1);
            end else begin
              r_ptr <= r_ptr + rw'(1);
            end
          end else begin
            // Hold pointers and data so the stalled beat is re-issued intact
            out_wr <= 1'b0;
            done   <= 1'b0;
          end
        end
        default: begin
          state   <= FILL;
          row_cnt <= {rw{1'b0}};
          r_ptr   <= {rw{1'b0}};
          c_ptr   <= {cw{1'b0}};
          out_wr  <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_serializer.sv
// Directed bench for psum_serializer: cycle vectors with expected outputs,
// plus hand-written async-reset sequences.
module tb_psum_serializer;

  localparam int PR  = 8;
  localparam int COL = 8;
  localparam int BW  = 4;
  localparam int PBW = 2*BW+4;
  localparam int DW  = COL*PBW;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           out_stall;
  logic           out_wr;
  logic [PBW-1:0] out_data;
  logic           done;

  always #5 clk = ~clk;

  psum_serializer #(.pr(PR), .col(COL), .bw(BW), .psum_bw(PBW)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_stall(out_stall),
    .out_wr   (out_wr),
    .out_data (out_data),
    .done     (done)
  );

  typedef struct {
    logic           valid;
    logic [DW-1:0]  data;
    logic           stall;
    logic           flush;
    logic           exp_ready;
    logic           exp_wr;
    logic [PBW-1:0] exp_data;
    logic           exp_done;
  } vec_t;

  vec_t           vq[$];
  logic [PBW-1:0] tile [0:PR-1][0:COL-1];
  logic [DW-1:0]  junk;
  int             errors = 0;
  int             checks = 0;

  task automatic check(input string name, input int idx,
                       input logic [PBW-1:0] got, input logic [PBW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, got, want);
    end
  endtask

  task automatic set_tile_ramp(input int seed);
    for (int r = 0; r < PR; r++)
      for (int c = 0; c < COL; c++)
        tile[r][c] = PBW'(seed + 16*r + c);
  endtask

  task automatic set_tile_sign();
    for (int r = 0; r < PR; r++)
      for (int c = 0; c < COL; c++)
        tile[r][c] = (r % 2 == 0) ? 12'hFFF : 12'h800;
  endtask

  function automatic logic [DW-1:0] row_bits(input int r);
    logic [DW-1:0] b;
    b = '0;
    for (int c = 0; c < COL; c++) b[c*PBW +: PBW] = tile[r][c];
    return b;
  endfunction

  task automatic push(input logic v, input logic [DW-1:0] d, input logic s,
                      input logic f, input logic er, input logic ew,
                      input logic [PBW-1:0] ed, input logic edn);
    vec_t x;
    x.valid = v; x.data = d; x.stall = s; x.flush = f;
    x.exp_ready = er; x.exp_wr = ew; x.exp_data = ed; x.exp_done = edn;
    vq.push_back(x);
  endtask

  // nrows captures; with gaps an idle cycle sits between valid rows
  task automatic push_fill(input int nrows, input bit gaps);
    for (int r = 0; r < nrows; r++) begin
      push(1'b1, row_bits(r), 1'b0, 1'b0, (r != PR-1), 1'b0, 12'h000, 1'b0);
      if (gaps && r < nrows-1)
        push(1'b0, junk, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    end
  endtask

  task automatic push_drain(input int nbeats, input bit stalls, input logic jv);
    int ns;
    bit last;
    for (int k = 0; k < nbeats; k++) begin
      ns = 0;
      if (stalls) ns = (k == 3 || (k >= 9 && k <= 11)) ? 1 : (k == 63) ? 2 : 0;
      for (int s = 0; s < ns; s++)
        push(jv, junk, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      last = (k == PR*COL-1);
      push(jv, junk, 1'b0, 1'b0, last, 1'b1, tile[k % PR][k / PR], last);
    end
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      in_valid  = vq[i].valid;
      in_data   = vq[i].data;
      out_stall = vq[i].stall;
      flush     = vq[i].flush;
      @(posedge clk);
      #1;
      check({tag, ".in_ready"}, i, PBW'(in_ready), PBW'(vq[i].exp_ready));
      check({tag, ".out_wr"},   i, PBW'(out_wr),   PBW'(vq[i].exp_wr));
      check({tag, ".done"},     i, PBW'(done),     PBW'(vq[i].exp_done));
      if (vq[i].exp_wr) check({tag, ".out_data"}, i, out_data, vq[i].exp_data);
    end
    in_valid = 1'b0; out_stall = 1'b0; flush = 1'b0;
    vq.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".in_ready"}, 0, PBW'(in_ready), 12'h001);
    check({tag, ".out_wr"},   0, PBW'(out_wr),   12'h000);
    check({tag, ".done"},     0, PBW'(done),     12'h000);
    check({tag, ".out_data"}, 0, out_data,       12'h000);
  endtask

  initial begin
    junk      = {8{12'hBAD}};
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_stall = 1'b0;
    in_data   = '0;
    #2;
    check_reset_state("reset0");
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic, then stall (same data, junk offered while draining), sign, gaps
    set_tile_ramp(0);
    push_fill(PR, 1'b0);
    push_drain(PR*COL, 1'b0, 1'b0);
    push_fill(PR, 1'b0);
    push_drain(PR*COL, 1'b1, 1'b1);
    set_tile_sign();
    push_fill(PR, 1'b0);
    push_drain(PR*COL, 1'b0, 1'b0);
    set_tile_ramp(12'h300);
    push_fill(PR, 1'b1);
    push_drain(PR*COL, 1'b0, 1'b0);
    // Flush at beat 20, flush overriding a valid row in FILL, fresh tile
    set_tile_ramp(12'h400);
    push_fill(PR, 1'b0);
    push_drain(20, 1'b0, 1'b0);
    push(1'b0, junk, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    push(1'b1, junk, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    set_tile_ramp(12'h500);
    push_fill(PR, 1'b0);
    push_drain(PR*COL, 1'b0, 1'b0);
    // Partial fill of rows 0..4, then async reset
    set_tile_ramp(12'h600);
    push_fill(5, 1'b0);
    run_vecs("p1");

    reset = 1'b1;
    #2;
    check_reset_state("reset_fill");
    @(posedge clk); #1;
    reset = 1'b0;

    set_tile_ramp(12'h700);
    push_fill(PR, 1'b0);
    push_drain(30, 1'b0, 1'b0);
    run_vecs("p2");

    // Reset mid-DRAIN discards the tile; next tile starts at row 0
    reset = 1'b1;
    #2;
    check_reset_state("reset_drain");
    @(posedge clk); #1;
    reset = 1'b0;

    set_tile_ramp(12'h800);
    push_fill(PR, 1'b0);
    push_drain(PR*COL, 1'b0, 1'b0);
    run_vecs("p3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psum_serializer.md
PSUM_SERIALIZER -- requirements
Module: psum_serializer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- pr, 8, rows per tile; also elements per column burst.
- col, 8, columns per row.
- bw, 4, operand width.
- psum_bw, 2*bw+4, partial-sum width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk input 1: clock.
- reset input 1: reset, asynchronous, active-high.
- flush input 1: synchronous abort, active-high.
- in_valid input 1: row present on in_data.
- in_ready output 1: block accepts a row this cycle.
- in_data input col*psum_bw: one row; column c at bits [(c+1)*psum_bw-1 : c*psum_bw].
- out_stall input 1: downstream hold request.
- out_wr output 1: write strobe to the downstream norm array.
- out_data output psum_bw: serialized psum.
- done output 1: one-cycle pulse on the final beat of a tile.

Function
REQ-003 The block SHALL implement two states:
- FILL (the reset state).
- DRAIN.
REQ-004 In FILL, in_ready SHALL be 1; in DRAIN, in_ready SHALL be 0; in_ready SHALL be combinational from state only.
REQ-005 A row SHALL be captured on a rising edge where in_valid=1 and in_ready=1.
- The row is stored into buffer row row_cnt, and row_cnt increments.
- in_valid=0 in FILL SHALL leave the buffer and row_cnt unchanged.
REQ-006 When the capture at row_cnt=pr-1 occurs:
- The state SHALL become DRAIN on that edge.
- row_cnt SHALL wrap to 0.
- r_ptr and c_ptr SHALL both be 0.
REQ-007 In DRAIN, on each edge with out_stall=0:
- out_wr SHALL be set to 1.
- out_data SHALL be set to buffer[r_ptr][c_ptr].
- r_ptr SHALL then advance.
- When r_ptr=pr-1, r_ptr SHALL wrap to 0 and c_ptr SHALL increment.
- Resulting order: column 0 rows 0..pr-1, then column 1, and so on through column col-1 (column-major, pr beats per column).
REQ-008 In DRAIN, on each edge with out_stall=1:
- out_wr SHALL be set to 0.
- out_data, r_ptr and c_ptr SHALL hold.
- No beat SHALL be lost or duplicated.
REQ-009 out_wr, out_data and done SHALL be registered. out_wr SHALL be 0 on every edge not emitting a beat, including all edges in FILL.
REQ-010 Latency: the first beat SHALL appear with out_wr=1 in the cycle after the DRAIN transition edge, given out_stall=0.
REQ-011 The beat for (r_ptr=pr-1, c_ptr=col-1) is the last beat. On the edge that emits it:
- done SHALL be set to 1 for exactly that cycle, coinciding with the last out_wr.
- The state SHALL return to FILL.
- A new row SHALL be acceptable on the following edge.
REQ-012 A tile SHALL produce exactly pr*col beats. Data SHALL pass bit-exact: signed two's complement, no rounding, no saturation.
REQ-013 flush=1 on an edge SHALL take priority over all other activity:
- state goes to FILL.
- row_cnt, r_ptr and c_ptr go to 0.
- out_wr and done go to 0.
- Buffer contents may be left unchanged but SHALL never be emitted.
REQ-014 in_valid while in DRAIN SHALL be ignored and nothing SHALL be captured; the upstream holds the row because in_ready=0.
REQ-015 Counter widths SHALL be sized to hold pr-1 and col-1 exactly. The pointers SHALL never index outside the buffer.

Reset
REQ-016 While reset=1, regardless of clk:
- state SHALL be FILL.
- row_cnt, r_ptr and c_ptr SHALL be 0.
- out_wr, done and out_data SHALL be 0.
- in_ready SHALL be 1.
REQ-017 Reset asserted mid-FILL or mid-DRAIN SHALL discard the partial tile. After release, the first captured row SHALL be stored as row 0.

Verification
REQ-018 The bench SHALL cover these directed scenarios (default parameters):
- Basic: 8 rows with element(r,c)=16*r+c, out_stall=0 -> in_ready low after 8th row; 64 beats in the following 64 cycles; beat k = 16*(k%8)+(k/8); done=1 only on beat 63.
- Stall: out_stall=1 on beats 3, 9-11 and 63 -> out_wr=0 on stalled cycles; same 64-value sequence; done delayed to the actual final beat.
- Sign: all rows = -1 (12'hFFF) and -2048 (12'h800) in alternate rows -> identical bit patterns out; no sign loss.
- Gaps: in_valid toggling 1,0,1,0... -> only valid rows captured; DRAIN entered only after 8 captures.
- Back-to-back: a second tile presented the cycle after done -> accepted immediately; second 64-beat sequence correct; no stale data.
- Abort: flush at beat 20, then reset at row 5 of the next fill -> out_wr=0 next cycle, in_ready=1; next tile emits from its own row 0 only.
